// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the push-button PWM generator.
package pwm_pkg;

    localparam int DEF_PERIOD          = 10;
    localparam int DEF_DUTY_INIT       = 5;
    localparam int DEF_DUTY_STEP       = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Net effect of the two press pulses in one cycle.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_DEC  = 2'd2
    } duty_cmd_e;

    // Duty must be able to hold every value 0..period inclusive.
    function automatic int duty_width(input int period);
        return (period < 1) ? 1 : $clog2(period + 1);
    endfunction

    // Period counter spans 0..period-1.
    function automatic int cnt_width(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to single-cycle press pulse: 2-FF synchroniser, counting
// debouncer and rising-edge detection on the debounced level.
module button_conditioner #(
    parameter int DEB_CYCLES = pwm_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int DBW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEB_CYCLES - 1);

    logic           sync1_reg;
    logic           sync2_reg;
    logic           level_reg;
    logic           press_reg;
    logic [DBW-1:0] db_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            level_reg  <= 1'b0;
            press_reg  <= 1'b0;
            db_cnt_reg <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample that agrees with the debounced level restarts the count.
            if (sync2_reg != level_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    level_reg  <= sync2_reg;
                    db_cnt_reg <= '0;
                    press_reg  <= sync2_reg;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/pwm_push_button.sv
// Single-channel PWM whose duty is stepped up/down by two debounced buttons;
// the duty is shadowed and only applied at the period boundary.
module pwm_push_button
    import pwm_pkg::*;
#(
    parameter int PERIOD          = DEF_PERIOD,
    parameter int DUTY_INIT       = DEF_DUTY_INIT,
    parameter int DUTY_STEP       = DEF_DUTY_STEP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic Button1,
    input  logic Button2,
    output logic pwm
);

    localparam int DW = duty_width(PERIOD);
    localparam int CW = cnt_width(PERIOD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DUTY_MAX  = DW'(PERIOD);
    localparam logic [DW-1:0] DUTY_RST  = DW'(DUTY_INIT);
    localparam logic [DW-1:0] STEP_DW   = DW'(DUTY_STEP);

    logic [1:0]    btn_raw;
    logic [1:0]    press;
    duty_cmd_e     cmd;

    logic [DW-1:0] duty_tgt_reg;
    logic [DW-1:0] duty_tgt_next;
    logic [DW-1:0] duty_act_reg;
    logic [CW-1:0] cnt_reg;
    logic          pwm_reg;
    logic [31:0]   duty_up;

    // Index 0 raises the duty, index 1 lowers it.
    assign btn_raw = {Button2, Button1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            button_conditioner #(
                .DEB_CYCLES(DEBOUNCE_CYCLES)
            ) u_cond (
                .clk   (clk),
                .rst   (rst),
                .btn_in(btn_raw[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    always_comb begin
        cmd = CMD_HOLD;
        case (press)
            2'b01:   cmd = CMD_INC;
            2'b10:   cmd = CMD_DEC;
            default: cmd = CMD_HOLD;
        endcase
    end

    // Saturating step; the sum is formed wide so it cannot wrap before the clamp.
    always_comb begin
        duty_up       = 32'(duty_tgt_reg) + 32'(DUTY_STEP);
        duty_tgt_next = duty_tgt_reg;
        case (cmd)
            CMD_INC: begin
                if (duty_up > 32'(PERIOD)) begin
                    duty_tgt_next = DUTY_MAX;
                end else begin
                    duty_tgt_next = DW'(duty_up);
                end
            end
            CMD_DEC: begin
                if (duty_tgt_reg < STEP_DW) begin
                    duty_tgt_next = '0;
                end else begin
                    duty_tgt_next = duty_tgt_reg - STEP_DW;
                end
            end
            default: duty_tgt_next = duty_tgt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_tgt_reg <= DUTY_RST;
            duty_act_reg <= DUTY_RST;
            cnt_reg      <= '0;
            pwm_reg      <= 1'b0;
        end else begin
            duty_tgt_reg <= duty_tgt_next;
            pwm_reg      <= (DW'(cnt_reg) < duty_act_reg);
            if (cnt_reg == CNT_LAST) begin
                cnt_reg      <= '0;
                duty_act_reg <= duty_tgt_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: tb/tb_pwm_push_button.sv
// Self-checking bench: table-driven press sequences, corner cases and a
// randomized press stream checked against a per-window duty model.
module tb_pwm_push_button;

    localparam int P    = 10;
    localparam int INIT = 5;
    localparam int STEP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b1  = 1'b0;
    logic b2  = 1'b0;
    logic pwm;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;
    int duty_m  = INIT;

    typedef struct {
        int inc;
        int dec;
        int exp_duty;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    pwm_push_button dut (
        .clk    (clk),
        .rst    (rst),
        .Button1(b1),
        .Button2(b2),
        .pwm    (pwm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) phase++;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: pwm=%0b expected %0b (phase %0d)", name, act, exp, phase);
        end
    endtask

    // Output of the k-th edge after reset is high iff (k mod P) < duty.
    task automatic check_window(input string name, input int duty);
        int highs;
        highs = 0;
        while ((phase % P) != 0) tick();
        for (int i = 0; i < P; i++) begin
            tick();
            check(name, pwm, (i < duty));
            if (pwm === 1'b1) highs++;
        end
        $display("[TB] %s: expected duty %0d, observed %0d high of %0d", name, duty, highs, P);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("reset_low", pwm, 1'b0);
        end
        rst    = 1'b0;
        phase  = 0;
        duty_m = INIT;
        $display("[TB] reset for %0d cycles", n);
    endtask

    task automatic press(input bit i1, input bit i2, input int hold, input int low);
        b1 = i1;
        b2 = i2;
        repeat (hold) tick();
        b1 = 1'b0;
        b2 = 1'b0;
        repeat (low) tick();
    endtask

    function automatic int clamp(input int v);
        if (v > P) return P;
        if (v < 0) return 0;
        return v;
    endfunction

    initial begin
        int r, hold, low;

        for (int i = 0; i < 6; i++)  vecs[i]     = '{1, 0, (i < 5) ? INIT + 1 + i : P};
        for (int i = 0; i < 11; i++) vecs[6 + i] = '{0, 1, (i < 10) ? P - 1 - i : 0};

        do_reset(5);
        for (int w = 0; w < 10; w++) check_window("idle", INIT);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].inc != 0, vecs[i].dec != 0, 10, 10);
            check_window($sformatf("vec%0d", i), vecs[i].exp_duty);
        end

        do_reset(2);
        press(1, 0, 2, 10);
        press(1, 0, 50, 10);
        check_window("glitch_then_hold", INIT + STEP);

        do_reset(2);
        press(1, 1, 10, 10);
        check_window("both_buttons", INIT);

        while ((phase % P) != 0) tick();
        b1 = 1'b1;
        check_window("mid_period_old", INIT);
        b1 = 1'b0;
        check_window("mid_period_new", INIT + STEP);

        press(1, 0, 10, 10);
        press(1, 0, 10, 10);
        check_window("duty8", 8);
        while ((phase % P) != 4) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_period", pwm, 1'b0);
        rst    = 1'b0;
        phase  = 0;
        duty_m = INIT;
        check_window("after_rst_a", INIT);
        check_window("after_rst_b", INIT);

        for (int n = 0; n < 25; n++) begin
            r    = int'($urandom_range(0, 3));
            hold = int'($urandom_range(6, 14));
            low  = int'($urandom_range(6, 12));
            case (r)
                0: begin press(1, 0, hold, low); duty_m = clamp(duty_m + STEP); end
                1: begin press(0, 1, hold, low); duty_m = clamp(duty_m - STEP); end
                2: press(1, 1, hold, low);
                default: begin
                    if ($urandom_range(0, 1) == 0) press(1, 0, int'($urandom_range(1, 3)), low);
                    else                           press(0, 1, int'($urandom_range(1, 3)), low);
                end
            endcase
            check_window($sformatf("rand%0d_op%0d", n, r), duty_m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_push_button.md
# pwm_push_button

Single-channel PWM generator whose duty cycle is adjusted at run time by two push buttons: Button1 raises the duty one step per press, Button2 lowers it one step per press. It sits between raw board buttons and an LED or driver pin. It contains its own input synchronisation, debouncing and edge detection, so the button pins may be wired directly to it.

## Interface
- PERIOD, 10: PWM period in clk cycles (≥2).
- DUTY_INIT, 5: duty value (high cycles per period) after reset; 0..PERIOD.
- DUTY_STEP, 1: duty increment/decrement per accepted press.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change (≥1).
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  reset; synchronous and active-high.
- Button1  in  1  asynchronous, active-high "increase duty" button.
- Button2  in  1  asynchronous, active-high "decrease duty" button.
- pwm  out  1  registered PWM output.

## Operation
- Each button passes through a 2-FF synchroniser and then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it.
  - A one-cycle press pulse fires on each debounced 0→1 transition. Releases generate nothing.
  - Holding a button does not auto-repeat.
- Duty target register `duty_tgt`, width clog2(PERIOD+1):
  - Inc pulse only: `duty_tgt = min(duty_tgt + DUTY_STEP, PERIOD)` (saturating).
  - Dec pulse only: `duty_tgt = max(duty_tgt − DUTY_STEP, 0)` (saturating, no wrap).
  - Both pulses in the same cycle: no change.
- Period counter `cnt` counts 0..PERIOD−1 and wraps to 0.
- Active duty `duty_act` loads `duty_tgt` on the cycle `cnt` wraps to 0. The duty therefore never changes mid-period, which avoids glitches.
- Output: `pwm <= (cnt < duty_act)`.
  - duty 0 → constant 0.
  - duty PERIOD → constant 1.
- Reset values: `cnt`=0, `duty_tgt`=`duty_act`=DUTY_INIT, `pwm`=0, synchronisers and debounced levels 0, debounce counters 0.
- Reset asserted mid-operation overrides everything in that cycle. A press being debounced at that point is discarded.

## Timing
- Press latency: the pulse fires 2 (sync) + DEBOUNCE_CYCLES cycles after the button is first sampled high. `duty_tgt` updates on the following edge.
- `duty_act` takes effect at the next counter wrap, i.e. within PERIOD cycles.
- `pwm` is registered and lags the `cnt` comparison by one cycle.
- Minimum press/release width for reliable acceptance: DEBOUNCE_CYCLES+2 cycles.
- Any glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- First cycle after reset release: `cnt`=0, so `pwm` rises on the next edge if DUTY_INIT>0.
- Steady state: in every PERIOD-cycle window aligned to the wrap, `pwm` is high for exactly `duty_act` consecutive cycles, starting at the wrap.

## Structure
- Shared package `pwm_pkg` holds:
  - default constants PERIOD, DUTY_INIT, DUTY_STEP, DEBOUNCE_CYCLES;
  - duty-width function clog2(PERIOD+1).
- One sub-module, `button_conditioner`, instantiated twice. It contains the synchroniser, debounce counter, debounced level and rising-edge pulse, with ports clk, rst, btn_in, press.
- The top level holds the duty register with saturation, the shadow load, the period counter and the output comparator.

## Test plan
- Reset, then idle 100 cycles → `pwm` has a 10-cycle period with 5 high, 5 low; `pwm`=0 while `rst`=1.
- Five Button1 presses (10 cycles high, 10 low each) → duty steps 6,7,8,9,10. After the last press `pwm` is constant 1; a 6th press keeps it at 10.
- Then ten Button2 presses → duty steps down to 0, `pwm` is constant 0; an 11th press keeps it at 0 with no wrap to 10.
- Button1 glitch of 2 cycles, then a held press of 50 cycles → glitch ignored; exactly one increment (5→6).
- Button1 and Button2 rising in the same cycle → duty stays 5. Press issued mid-period → high time changes only from the next wrap.
- Assert `rst` for 1 cycle mid-period with duty 8 → next cycle `cnt`=0, duty=5, `pwm`=0; normal 5/10 pattern resumes.
